sg_filter_ctrl: RTL and testbench
=================================

Name: sg_filter_ctrl

Overview:
- Frame-based sequencer for the Savitzky-Golay smoothing datapath.
- Accepts ADC samples over a valid/ready stream and keeps a circular 15-sample window.
- Per output point, drives a shared symmetric multiply-accumulate unit, using pre-added sample pairs and a coefficient index.
- Emits the filtered stream with edge padding, so the output count equals the input frame length.

Parameters:
- DATA_W, 8: ADC sample width, unsigned.
- HALF_WIN, 7: filter half-width. Window is 2*HALF_WIN+1 = 15 taps.
- ACC_W, 32: MAC result and output width, signed, passed through unchanged.
- LEN_W, 16: frame length counter width.
- MAC_LAT, 1: cycles from the last mac_en to a valid mac_result.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame (sampled only in IDLE)
- frame_len  in  LEN_W  samples in the frame, captured on start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at frame end
- err  out  1  one-cycle pulse with done when frame_len < 2*HALF_WIN+1
- in_valid  in  1  sample valid
- in_ready  out  1  controller accepts sample
- in_data  in  DATA_W  ADC sample
- mac_clr  out  1  clear accumulator; asserted with the first op of each point
- mac_en  out  1  accumulate pair_sum*coef[coef_idx]
- coef_idx  out  4  coefficient index 0..HALF_WIN
- pair_sum  out  DATA_W+1  pre-added sample pair, unsigned
- mac_result  in  ACC_W  accumulator value
- out_valid  out  1  filtered sample valid
- out_ready  in  1  downstream accepts
- out_data  out  ACC_W  filtered sample

Behaviour:
- Reset values (asynchronous on rst_n low): state IDLE. busy, done, err, in_ready, mac_clr, mac_en, out_valid all 0. coef_idx, pair_sum, out_data 0. Window contents and all counters cleared.
- Reset mid-frame abandons the frame. No done pulse is issued.
- IDLE:
  - start with frame_len >= 15: capture N = frame_len, busy=1, go to FILL.
  - start with frame_len < 15: next cycle done=1 and err=1; stay IDLE. No samples are consumed.
  - start while busy is ignored.
- FILL: in_ready=1. Accept 15 samples; each handshake writes the window at wr_ptr (mod 15). After the 15th, go to MAC.
- MAC: 8 consecutive cycles, j = 0..7, mac_en=1, coef_idx=j.
  - mac_clr=1 only at j=0.
  - For j < 7: pair_sum = s[c-(7-j)] + s[c+(7-j)], where c is the window centre.
  - For j = 7: pair_sum = zero-extended s[c].
  - Window indices wrap mod 15.
- WAIT: MAC_LAT cycles with mac_en=0, then latch mac_result into out_data. Go to EMIT.
- EMIT: out_valid=1 and out_data held stable until out_ready. Repeat count per computed point k (1..N-14):
  - first point (k=1): HALF_WIN+1 = 8 copies (left pad);
  - last point (k=N-14): 8 copies (right pad);
  - if k is both first and last (N=15): 15 copies;
  - otherwise: 1 copy.
  - Total out handshakes per frame = N.
- EMIT exit:
  - more points remain: go to SHIFT;
  - otherwise: done=1 for one cycle, busy=0, go to IDLE.
- SHIFT: in_ready=1 until one sample is accepted. It overwrites the oldest entry and advances the centre by 1. Go to MAC.
- Pipeline rules:
  - in_ready=0 in MAC, WAIT and EMIT.
  - The controller never accepts more than N samples per frame.
  - out_valid never drops without an out_ready handshake.
  - No MAC op is issued while out_valid=1.
- in_valid=0 during FILL or SHIFT stalls the controller indefinitely; no timeout.
- frame_len changes after start have no effect.
- Counters: samples accepted, points computed and copies emitted, each LEN_W wide. No wrap within a legal frame.

Test Plan:
- Bench MAC model uses integer coefs 1..8 for idx 0..7. N=15, all samples 10 → 8 MAC ops with mac_clr on the first; single result 10*(2*(1+...+7)+8) = 640 emitted 15 times; done with err=0.
- N=20, ramp 0..19 → first out_data value ×8, 4 middle values, last value ×8; 20 handshakes; exactly 20 in handshakes; pair_sum for j=0 of the first point = 0+14 = 14.
- Backpressure: out_ready low for 5 cycles during EMIT → out_data and out_valid stable, in_ready=0, mac_en=0; resumes without loss or duplication.
- frame_len=10 → done=1 and err=1 on the cycle after start; in_ready never asserted; busy stays 0.
- rst_n low during the MAC state of the third point → all outputs 0 immediately, no done. A following start with N=15 completes normally.
- Second start pulse while busy, plus in_valid held 0 for 20 cycles in SHIFT → start ignored; controller stalls, then continues correctly.

Source files
------------

// File: rtl/sg_filter_ctrl.sv
// Frame sequencer for the Savitzky-Golay smoothing datapath: keeps a circular
// sample window, drives a shared symmetric MAC and emits an edge-padded output stream.
module sg_filter_ctrl #(
    parameter int DATA_W   = 8,
    parameter int HALF_WIN = 7,
    parameter int ACC_W    = 32,
    parameter int LEN_W    = 16,
    parameter int MAC_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [3:0]        coef_idx,
    output logic [DATA_W:0]   pair_sum,
    input  logic [ACC_W-1:0]  mac_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data
);

    localparam int WIN   = 2 * HALF_WIN + 1;
    localparam int PTR_W = $clog2(WIN);

    localparam logic [LEN_W-1:0] WIN_L     = LEN_W'(WIN);
    localparam logic [LEN_W-1:0] FILL_LAST = LEN_W'(WIN - 1);
    localparam logic [LEN_W-1:0] PAD_LAST  = LEN_W'(HALF_WIN);
    localparam logic [3:0]       HALF_IDX  = 4'(HALF_WIN);
    localparam logic [3:0]       LAT_LAST  = 4'(MAC_LAT - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(WIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_MAC,
        S_WAIT,
        S_EMIT,
        S_SHIFT
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] win_mem [WIN];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  lo_idx, hi_idx;
    logic [3:0]        op_cnt;
    logic [LEN_W-1:0]  samp_cnt, pt_cnt, copy_cnt, pt_last, copy_last;
    logic              pt_first, pt_final, in_hs, out_hs;

    // Valid/ready: a transfer happens on a rising edge where both valid and ready
    // are high; ready never depends on valid, and valid stays up until accepted.
    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;
    assign busy   = (state != S_IDLE);

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                  input logic [PTR_W-1:0] b);
        logic [PTR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (PTR_W+1)'(WIN)) s = s - (PTR_W+1)'(WIN);
        return s[PTR_W-1:0];
    endfunction

    // wr_ptr always points at the oldest sample, so tap j pairs oldest+j with oldest+WIN-1-j.
    assign lo_idx = wrap_add(wr_ptr, PTR_W'(op_cnt));
    assign hi_idx = wrap_add(wr_ptr, LAST_PTR - PTR_W'(op_cnt));

    assign pt_first = (pt_cnt == '0);
    assign pt_final = (pt_cnt == pt_last);

    always_comb begin
        copy_last = '0;
        if (pt_first && pt_final)      copy_last = FILL_LAST;
        else if (pt_first || pt_final) copy_last = PAD_LAST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        coef_idx  = '0;
        pair_sum  = '0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && frame_len >= WIN_L) state_nxt = S_FILL;
            end
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid && samp_cnt == FILL_LAST) state_nxt = S_MAC;
            end
            S_MAC: begin
                mac_en   = 1'b1;
                mac_clr  = (op_cnt == 4'd0);
                coef_idx = op_cnt;
                if (op_cnt == HALF_IDX) begin
                    pair_sum  = {1'b0, win_mem[lo_idx]};
                    state_nxt = S_WAIT;
                end else begin
                    pair_sum = {1'b0, win_mem[lo_idx]} + {1'b0, win_mem[hi_idx]};
                end
            end
            S_WAIT: begin
                if (op_cnt == LAT_LAST) state_nxt = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready && copy_cnt == copy_last)
                    state_nxt = pt_final ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_MAC;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            op_cnt   <= '0;
            samp_cnt <= '0;
            pt_cnt   <= '0;
            copy_cnt <= '0;
            pt_last  <= '0;
            out_data <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < WIN; i++) win_mem[i] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (frame_len < WIN_L) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            pt_last  <= frame_len - WIN_L;
                            wr_ptr   <= '0;
                            op_cnt   <= '0;
                            samp_cnt <= '0;
                            pt_cnt   <= '0;
                            copy_cnt <= '0;
                        end
                    end
                end
                S_FILL, S_SHIFT: begin
                    if (in_hs) begin
                        win_mem[wr_ptr] <= in_data;
                        wr_ptr   <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
                        samp_cnt <= samp_cnt + LEN_W'(1);
                    end
                end
                S_MAC: begin
                    op_cnt <= (op_cnt == HALF_IDX) ? 4'd0 : op_cnt + 4'd1;
                end
                S_WAIT: begin
                    if (op_cnt == LAT_LAST) begin
                        op_cnt   <= 4'd0;
                        out_data <= mac_result;
                    end else begin
                        op_cnt <= op_cnt + 4'd1;
                    end
                end
                S_EMIT: begin
                    if (out_hs) begin
                        if (copy_cnt == copy_last) begin
                            copy_cnt <= '0;
                            pt_cnt   <= pt_cnt + LEN_W'(1);
                            if (pt_final) done <= 1'b1;
                        end else begin
                            copy_cnt <= copy_cnt + LEN_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sg_filter_ctrl.sv
// Bench for sg_filter_ctrl: a simple MAC stand-in plus a direct-convolution
// reference that predicts the padded output stream of each frame.
module tb_sg_filter_ctrl;

    localparam int DATA_W   = 8;
    localparam int HALF_WIN = 7;
    localparam int ACC_W    = 32;
    localparam int LEN_W    = 16;
    localparam int MAC_LAT  = 1;

    localparam int MODE_NONE  = 0;
    localparam int MODE_BP    = 1;
    localparam int MODE_RST   = 2;
    localparam int MODE_STALL = 3;
    localparam int SAMP_N     = 80;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  frame_len;
    logic              busy, done, err;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic              mac_clr, mac_en;
    logic [3:0]        coef_idx;
    logic [DATA_W:0]   pair_sum;
    logic [ACC_W-1:0]  mac_result;
    logic              out_valid, out_ready;
    logic [ACC_W-1:0]  out_data;

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] samp [SAMP_N];
    logic [ACC_W-1:0]  first_out;
    int                first_pair;

    always #5 clk = ~clk;

    sg_filter_ctrl #(
        .DATA_W(DATA_W), .HALF_WIN(HALF_WIN), .ACC_W(ACC_W), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .busy(busy), .done(done), .err(err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mac_clr(mac_clr), .mac_en(mac_en), .coef_idx(coef_idx), .pair_sum(pair_sum),
        .mac_result(mac_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // MAC stand-in with coefficient idx+1, result visible one cycle after the last op.
    logic [ACC_W-1:0] acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else if (mac_en)
            acc <= (mac_clr ? '0 : acc) + ACC_W'(int'(pair_sum) * (int'(coef_idx) + 1));
    end
    assign mac_result = acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int i);
        return (i >= 0 && i < SAMP_N) ? int'(samp[i]) : 0;
    endfunction

    // Smoothed point k is the 15-tap convolution with weights 1..8..1 over samples k..k+14.
    function automatic void build_expect(input int n);
        int p, y;
        int pts[$];
        exp_q.delete();
        p = n - 2 * HALF_WIN;
        for (int k = 0; k < p; k++) begin
            y = 0;
            for (int t = 0; t <= 2 * HALF_WIN; t++)
                y += ((t <= HALF_WIN) ? t + 1 : 2 * HALF_WIN + 1 - t) * pick(k + t);
            pts.push_back(y);
        end
        if (p == 1) begin
            for (int c = 0; c < 2 * HALF_WIN + 1; c++) exp_q.push_back(ACC_W'(pts[0]));
        end else begin
            for (int c = 0; c < HALF_WIN + 1; c++) exp_q.push_back(ACC_W'(pts[0]));
            for (int k = 1; k < p - 1; k++) exp_q.push_back(ACC_W'(pts[k]));
            for (int c = 0; c < HALF_WIN + 1; c++) exp_q.push_back(ACC_W'(pts[p-1]));
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {busy, done, err, in_ready, mac_clr, mac_en, out_valid}, 0);
        check({tag, "_coef_idx"}, coef_idx, 0);
        check({tag, "_pair_sum"}, pair_sum, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    task automatic run_frame(input int n, input int mode, input int vpct, input int rpct);
        int in_cnt, out_cnt, ops, kp, jj, exp_ps, hold_in, hold_out;
        bit got_done, aborted, bp_pending, stall_pending, prev_wait;
        logic [ACC_W-1:0] prev_data, exp_v;
        in_cnt = 0; out_cnt = 0; ops = 0; hold_in = 0; hold_out = 0;
        got_done = 0; aborted = 0; prev_wait = 0; prev_data = '0;
        bp_pending = 1; stall_pending = 1;
        first_pair = -1; first_out = '0;
        build_expect(n);
        @(negedge clk);
        start = 1'b1; frame_len = LEN_W'(n); in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        frame_len = LEN_W'($urandom_range(0, 9));
        check("busy_after_start", busy, 1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            start = 1'b0;
            if (done) begin
                got_done = 1;
                break;
            end
            check("no_err_in_frame", err, 0);
            if (prev_wait) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid) check("emit_quiet", {in_ready, mac_en}, 2'b00);
            if (mac_en) begin
                kp = ops / 8;
                jj = ops % 8;
                exp_ps = (jj < HALF_WIN) ? pick(kp + jj) + pick(kp + 2 * HALF_WIN - jj)
                                         : pick(kp + HALF_WIN);
                if (ops == 0) first_pair = int'(pair_sum);
                check("mac_clr", mac_clr, (jj == 0));
                check("coef_idx", coef_idx, jj);
                check("pair_sum", pair_sum, exp_ps);
                ops++;
                if (mode == MODE_RST && kp == 2) begin
                    rst_n = 1'b0;
                    #1;
                    check_all_zero("rst_mid");
                    @(negedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                    in_valid = 1'b0;
                    out_ready = 1'b0;
                    repeat (4) begin
                        @(negedge clk);
                        check("rst_no_done", {done, busy}, 2'b00);
                    end
                    aborted = 1;
                    break;
                end
            end
            if (mode == MODE_STALL && stall_pending && in_ready && in_cnt >= 15) begin
                stall_pending = 0;
                hold_in = 20;
            end
            if (hold_in > 0) begin
                in_valid = 1'b0;
                check("stall_in_ready", in_ready, 1);
                check("stall_busy", busy, 1);
                if (hold_in == 10) begin
                    start = 1'b1;
                    frame_len = LEN_W'(12);
                end
                hold_in--;
            end else begin
                in_valid = ($urandom_range(0, 99) < vpct);
            end
            in_data = samp[(in_cnt < SAMP_N) ? in_cnt : 0];
            if (mode == MODE_BP && bp_pending && out_valid && out_cnt >= 8) begin
                bp_pending = 0;
                hold_out = 5;
            end
            if (hold_out > 0) begin
                out_ready = 1'b0;
                hold_out--;
            end else begin
                out_ready = ($urandom_range(0, 99) < rpct);
            end
            if (in_valid && in_ready) in_cnt++;
            if (out_valid && out_ready) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (out_cnt == 0) first_out = out_data;
                check("out_data", out_data, exp_v);
                out_cnt++;
            end
            prev_wait = out_valid && !out_ready;
            prev_data = out_data;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        start = 1'b0;
        if (aborted) begin
            exp_q.delete();
            return;
        end
        check("frame_done_seen", got_done, 1);
        if (got_done) begin
            check("done_err", err, 0);
            check("done_busy", busy, 0);
            check("in_count", in_cnt, n);
            check("out_count", out_cnt, n);
            check("mac_ops", ops, 8 * (n - 2 * HALF_WIN));
            check("exp_left", exp_q.size(), 0);
            @(negedge clk);
            check("done_pulse", done, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; frame_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Short frame: error pulse, nothing consumed.
        start = 1'b1; frame_len = LEN_W'(10); in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("short_done_err", {done, err}, 2'b11);
        check("short_busy_rdy", {busy, in_ready}, 2'b00);
        repeat (3) begin
            @(negedge clk);
            check("short_after", {done, err, busy, in_ready}, 4'b0000);
        end
        in_valid = 1'b0;

        // N=15, constant 10: one point emitted 15 times.
        for (int i = 0; i < SAMP_N; i++) samp[i] = 8'd10;
        run_frame(15, MODE_NONE, 100, 100);
        check("const_value", first_out, 640);

        // N=20 ramp.
        for (int i = 0; i < SAMP_N; i++) samp[i] = DATA_W'(i);
        run_frame(20, MODE_NONE, 100, 100);
        check("ramp_pair0", first_pair, 14);

        // Downstream backpressure in the middle of a frame.
        for (int i = 0; i < SAMP_N; i++) samp[i] = DATA_W'($urandom_range(0, 255));
        run_frame(22, MODE_BP, 100, 100);

        // Reset during the third point's MAC, then a normal N=15 frame.
        for (int i = 0; i < SAMP_N; i++) samp[i] = DATA_W'($urandom_range(0, 255));
        run_frame(25, MODE_RST, 100, 100);
        for (int i = 0; i < SAMP_N; i++) samp[i] = DATA_W'($urandom_range(0, 255));
        run_frame(15, MODE_NONE, 90, 90);

        // Input stall in SHIFT with a stray start pulse.
        for (int i = 0; i < SAMP_N; i++) samp[i] = DATA_W'($urandom_range(0, 255));
        run_frame(24, MODE_STALL, 80, 80);

        // Random frames with random handshake gaps.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < SAMP_N; i++) samp[i] = DATA_W'($urandom_range(0, 255));
            run_frame($urandom_range(15, 40), MODE_NONE, $urandom_range(40, 100),
                      $urandom_range(40, 100));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
